fifo_rd_ctrl: RTL and testbench

Read-domain controller for the AHB2AHB bridge async FIFO.
- Synchronises the write-domain Gray pointer into r_clk and maintains the read pointer in binary and Gray form.
- Drives the read address to the FIFO memory and registers the returned word into an output stage with valid/ready handshake.
- Reports empty, almost-empty and occupancy level.
- Generalises the plain read mux with configurable sync depth, first-word-fall-through (FWFT) or standard read mode, flags and a level count.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_rd_ctrl_gray_sync.sv | 26 ++
 rtl/fifo_rd_ctrl.sv | 95 +++++++++
 tb/tb_fifo_rd_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO read and write controllers.
// The Gray helpers are width-agnostic: callers zero-extend into 32 bits and truncate the result.
package fifo_pkg;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  function automatic bit depth_ok(input int f_depth, input int p_size);
    return (p_size >= 2) && (f_depth == (1 << (p_size - 1)));
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_gray_sync.sv
// N-stage multi-bit synchroniser for a Gray-coded pointer crossing into the local clock.
// It has an asynchronous active-high reset, and the write-side controller reuses it.
module gray_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller for the bridge async FIFO: it holds the pointers and flags and drives the output stage.
// Handshake: in FWFT mode a word transfers on an edge where r_valid && r_ready. In standard mode r_ready is a read enable, and the word appears one cycle later with r_valid.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int D_SIZE      = 16,
  parameter int F_DEPTH     = 8,
  parameter int P_SIZE      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_LEVEL    = 1,
  parameter int FWFT        = 1
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic [P_SIZE-1:0] w_gptr,
  input  logic [D_SIZE-1:0] r_mem_data,
  output logic [P_SIZE-2:0] r_addr,
  output logic [P_SIZE-1:0] r_gptr,
  output logic [D_SIZE-1:0] r_data,
  output logic              r_valid,
  input  logic              r_ready,
  output logic              r_empty,
  output logic              r_almost_empty,
  output logic [P_SIZE-1:0] r_level,
  output logic              r_underflow
);

  if (!depth_ok(F_DEPTH, P_SIZE)) begin : g_bad_depth
    $error("fifo_rd_ctrl: F_DEPTH must equal 2**(P_SIZE-1)");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("fifo_rd_ctrl: SYNC_STAGES must be at least 2");
  end

  logic [P_SIZE-1:0] r_bptr;
  logic [P_SIZE-1:0] w_gptr_s;
  logic [P_SIZE-1:0] w_wbin_s;
  logic [P_SIZE-1:0] w_bptr_nxt;
  logic [P_SIZE-1:0] w_mem_level;
  logic              w_mem_empty;
  logic              w_pop;

  gray_sync #(
    .WIDTH  (P_SIZE),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .i_clk (r_clk),
    .i_rst (r_rst),
    .i_d   (w_gptr),
    .o_q   (w_gptr_s)
  );

  assign w_wbin_s    = P_SIZE'(gray2bin(32'(w_gptr_s)));
  assign w_bptr_nxt  = r_bptr + P_SIZE'(1);
  assign w_mem_empty = (r_bptr == w_wbin_s);
  assign w_mem_level = w_wbin_s - r_bptr;
  assign r_addr      = r_bptr[P_SIZE-2:0];

  // In FWFT mode the output register prefetches whenever it is empty or being drained.
  always_comb begin
    w_pop = 1'b0;
    if (FWFT != 0) w_pop = !w_mem_empty && (!r_valid || r_ready);
    else           w_pop = r_ready && !w_mem_empty;
  end

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_bptr      <= '0;
      r_gptr      <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_bptr <= w_bptr_nxt;
        r_gptr <= P_SIZE'(bin2gray(32'(w_bptr_nxt)));
        r_data <= r_mem_data;
      end
      if (FWFT != 0) begin
        if (w_pop)        r_valid <= 1'b1;
        else if (r_ready) r_valid <= 1'b0;
        r_underflow <= 1'b0;
      end else begin
        r_valid     <= w_pop;
        r_underflow <= r_ready && w_mem_empty;
      end
    end
  end

  // The FWFT level can reach F_DEPTH+1. The wrap bit in P_SIZE gives the headroom for this.
  assign r_level        = (FWFT != 0) ? w_mem_level + P_SIZE'(r_valid) : w_mem_level;
  assign r_empty        = (FWFT != 0) ? !r_valid : w_mem_empty;
  assign r_almost_empty = (int'(r_level) <= AE_LEVEL);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: one FWFT instance and one standard-mode instance, each fed from a memory model.
// Expected words come from a queue of everything written, in order.
module tb_fifo_rd_ctrl;

  localparam int DW = 16;
  localparam int PW = 4;
  localparam int AW = 3;

  logic r_clk = 1'b0;
  logic r_rst;
  always #5 r_clk = ~r_clk;

  // FWFT instance (a)
  logic [PW-1:0] w_gptr_a, r_gptr_a, r_level_a;
  logic [AW-1:0] r_addr_a;
  logic [DW-1:0] r_data_a, mem_data_a;
  logic          r_valid_a, r_ready_a, r_empty_a, r_ae_a, r_uf_a;
  logic [DW-1:0] mem_a [8];

  // Standard-mode instance (b)
  logic [PW-1:0] w_gptr_b, r_gptr_b, r_level_b;
  logic [AW-1:0] r_addr_b;
  logic [DW-1:0] r_data_b, mem_data_b;
  logic          r_valid_b, r_ready_b, r_empty_b, r_ae_b, r_uf_b;
  logic [DW-1:0] mem_b [8];

  assign mem_data_a = mem_a[r_addr_a];
  assign mem_data_b = mem_b[r_addr_b];

  fifo_rd_ctrl #(.FWFT(1)) dut_a (
    .r_clk(r_clk), .r_rst(r_rst), .w_gptr(w_gptr_a), .r_mem_data(mem_data_a),
    .r_addr(r_addr_a), .r_gptr(r_gptr_a), .r_data(r_data_a), .r_valid(r_valid_a),
    .r_ready(r_ready_a), .r_empty(r_empty_a), .r_almost_empty(r_ae_a),
    .r_level(r_level_a), .r_underflow(r_uf_a)
  );

  fifo_rd_ctrl #(.FWFT(0)) dut_b (
    .r_clk(r_clk), .r_rst(r_rst), .w_gptr(w_gptr_b), .r_mem_data(mem_data_b),
    .r_addr(r_addr_b), .r_gptr(r_gptr_b), .r_data(r_data_b), .r_valid(r_valid_b),
    .r_ready(r_ready_b), .r_empty(r_empty_b), .r_almost_empty(r_ae_b),
    .r_level(r_level_b), .r_underflow(r_uf_b)
  );

  int            n_vec  = 0;
  int            n_fail = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_b [$];
  logic [PW-1:0] wbin_a, wbin_b;

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [DW-1:0] d);
    mem_a[wbin_a[AW-1:0]] = d;
    wbin_a   = wbin_a + 1'b1;
    w_gptr_a = to_gray(wbin_a);
    exp_q.push_back(d);
  endtask

  task automatic push_b(input logic [DW-1:0] d);
    mem_b[wbin_b[AW-1:0]] = d;
    wbin_b   = wbin_b + 1'b1;
    w_gptr_b = to_gray(wbin_b);
    exp_b.push_back(d);
  endtask

  // Checks instance a against the expected queue. A word is consumed if r_ready is applied to the coming edge.
  task automatic sb_check();
    if (r_valid_a) begin
      if (exp_q.size() == 0) check("spurious_valid", r_valid_a, 0);
      else begin
        check("fwft_data", r_data_a, exp_q[0]);
        if (r_ready_a) void'(exp_q.pop_front());
      end
    end
    check("empty_vs_valid", r_empty_a, !r_valid_a);
  endtask

  task automatic sb_step();
    sb_check();
    @(negedge r_clk);
  endtask

  task automatic drain_a(input int budget);
    r_ready_a = 1'b1;
    for (int i = 0; i < budget && exp_q.size() > 0; i++) sb_step();
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
    r_ready_a = 1'b0;
  endtask

  task automatic do_reset();
    r_rst = 1'b1;
    wbin_a = '0; wbin_b = '0; w_gptr_a = '0; w_gptr_b = '0;
    exp_q.delete(); exp_b.delete();
    repeat (3) @(negedge r_clk);
    r_rst = 1'b0;
    @(negedge r_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w0, w1;
    logic [3:0]    pat;
    r_ready_a = 1'b0; r_ready_b = 1'b0;
    for (int i = 0; i < 8; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    do_reset();

    // Reset state
    check("rst_valid_a", r_valid_a, 0);
    check("rst_empty_a", r_empty_a, 1);
    check("rst_level_a", r_level_a, 0);
    check("rst_ae_a",    r_ae_a,    1);
    check("rst_gptr_a",  r_gptr_a,  0);
    check("rst_addr_a",  r_addr_a,  0);
    check("rst_valid_b", r_valid_b, 0);
    check("rst_empty_b", r_empty_b, 1);
    check("rst_uf_b",    r_uf_b,    0);

    // A single FWFT word appears on the third edge after the pointer changes.
    push_a(16'hA5A5);
    @(negedge r_clk); @(negedge r_clk);
    check("lat_early_valid", r_valid_a, 0);
    @(negedge r_clk);
    check("lat_valid", r_valid_a, 1);
    check("lat_data",  r_data_a,  16'hA5A5);
    check("lat_gptr",  r_gptr_a,  4'b0001);
    check("lat_level", r_level_a, 1);
    check("lat_ae",    r_ae_a,    1);
    r_ready_a = 1'b1;
    sb_step();
    r_ready_a = 1'b0;
    check("single_valid_off", r_valid_a, 0);
    check("single_empty",     r_empty_a, 1);
    check("single_level",     r_level_a, 0);

    // Full memory, then wrap through both passes of the pointer.
    do_reset();
    for (int i = 0; i < 8; i++) push_a(DW'(16'h1000 + i));
    repeat (4) @(negedge r_clk);
    check("full_level", r_level_a, 8);
    check("full_ae",    r_ae_a,    0);
    check("full_valid", r_valid_a, 1);
    r_ready_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("wrap_valid", r_valid_a, 1);
      check("wrap_addr",  r_addr_a, (i + 1) % 8);
      sb_step();
    end
    r_ready_a = 1'b0;
    check("wrap_empty", r_empty_a, 1);
    check("wrap_gptr",  r_gptr_a,  4'b1100);
    check("wrap_addr0", r_addr_a,  0);
    for (int i = 0; i < 8; i++) push_a(DW'(16'h2000 + i));
    repeat (4) @(negedge r_clk);
    check("pass2_level", r_level_a, 8);
    r_ready_a = 1'b1;
    repeat (8) sb_step();
    r_ready_a = 1'b0;
    check("pass2_gptr",  r_gptr_a,  4'b0000);
    check("pass2_addr",  r_addr_a,  0);
    check("pass2_empty", r_empty_a, 1);

    // Backpressure with a 1,0,0,1 ready pattern.
    pat = 4'b1001;
    for (int i = 0; i < 4; i++) push_a(DW'($urandom));
    for (int k = 0; k < 32 && exp_q.size() > 0; k++) begin
      r_ready_a = pat[k % 4];
      sb_step();
    end
    if (exp_q.size() > 0) check("bp_timeout", exp_q.size(), 0);
    r_ready_a = 1'b0;

    // Random traffic against the queue model.
    for (int k = 0; k < 400; k++) begin
      r_ready_a = 1'($urandom_range(0, 1));
      sb_check();
      check("level_bound", (r_level_a <= 4'd9), 1);
      if (exp_q.size() < 8 && $urandom_range(0, 1) == 1) push_a(DW'($urandom));
      @(negedge r_clk);
    end
    drain_a(80);
    repeat (4) @(negedge r_clk);
    check("rand_end_level", r_level_a, 0);
    check("rand_end_empty", r_empty_a, 1);

    // Standard read-enable mode: underflow, then two reads.
    r_ready_b = 1'b1;
    @(negedge r_clk);
    check("uf_pulse", r_uf_b,   1);
    check("uf_gptr",  r_gptr_b, 0);
    check("uf_valid", r_valid_b, 0);
    r_ready_b = 1'b0;
    @(negedge r_clk);
    check("uf_clear", r_uf_b, 0);
    w0 = DW'($urandom); w1 = DW'($urandom);
    push_b(w0); push_b(w1);
    repeat (4) @(negedge r_clk);
    check("std_level", r_level_b, 2);
    check("std_empty", r_empty_b, 0);
    check("std_ae",    r_ae_b,    0);
    r_ready_b = 1'b1;
    @(negedge r_clk);
    check("std_valid0", r_valid_b, 1);
    check("std_data0",  r_data_b,  exp_b.pop_front());
    check("std_uf0",    r_uf_b,    0);
    @(negedge r_clk);
    check("std_valid1", r_valid_b, 1);
    check("std_data1",  r_data_b,  exp_b.pop_front());
    check("std_uf1",    r_uf_b,    0);
    r_ready_b = 1'b0;
    @(negedge r_clk);
    check("std_valid_off", r_valid_b, 0);
    check("std_empty2",    r_empty_b, 1);
    check("std_gptr",      r_gptr_b,  4'b0011);
    check("std_level0",    r_level_b, 0);

    // Reset in the middle of a stream takes effect without a clock edge.
    for (int i = 0; i < 5; i++) push_a(DW'($urandom));
    repeat (4) @(negedge r_clk);
    check("mid_level", r_level_a, 5);
    check("mid_valid", r_valid_a, 1);
    #2;
    r_rst = 1'b1;
    wbin_a = '0; w_gptr_a = '0; exp_q.delete();
    #1;
    check("arst_valid", r_valid_a, 0);
    check("arst_level", r_level_a, 0);
    check("arst_gptr",  r_gptr_a,  0);
    check("arst_empty", r_empty_a, 1);
    @(negedge r_clk);
    r_rst = 1'b0;
    @(negedge r_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
